// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the PC fetch sequencer.
package pc_seq_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Plain-vector copies of the state encoding for the FSM register.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_HOLD = HOLD;

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Fetch-side bus: instruction memory req/ack, decode valid/ready, execute redirect.
interface pc_fetch_seq_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_addr;

  // The sequencer side.
  modport master (
    output imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redir_valid, redir_addr
  );

  // Memory, decode and execute side.
  modport slave (
    input  imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redir_valid, redir_addr
  );
endinterface

// File: rtl/pc_incr.sv
// Sequential-fetch PC adder; the sum wraps modulo 2^ADDR_W.
module pc_incr #(
  parameter int ADDR_W = 8,
  parameter int STEP   = 1
) (
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] y
);
  assign y = a + ADDR_W'(STEP);
endmodule

// File: rtl/pc_fetch_seq.sv
// PC fetch sequencer: owns the PC, issues one imem fetch at a time, holds the
// fetched instruction for decode and applies execute redirects.
// Optional feature macro: PC_SEQ_TIMEOUT_EN (fetch-wait timeout, sticky fetch_err).
module pc_fetch_seq
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int STEP     = 1,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           halt,
  output logic           busy,
  output logic           fetch_err,
  pc_fetch_seq_if.master bus
);

  logic [1:0]         state, next_state;
  logic [ADDR_W-1:0]  pc, next_pc, pc_plus;
  logic [INSTR_W-1:0] held_instr, next_instr;
  logic [ADDR_W-1:0]  held_pc, next_held_pc;
  logic               valid, next_valid;
  logic               req;

  pc_incr #(.ADDR_W(ADDR_W), .STEP(STEP)) u_incr (.a(pc), .y(pc_plus));

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             timeout_hit;
  logic             err;
`endif

  // Next-state logic; redirect outranks both ack and ready.
  always_comb begin
    next_state   = state;
    next_pc      = pc;
    next_instr   = held_instr;
    next_held_pc = held_pc;
    next_valid   = valid;
`ifdef PC_SEQ_TIMEOUT_EN
    next_cnt     = {CNT_W{1'b0}};
    timeout_hit  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.redir_valid) begin
          next_pc = bus.redir_addr;
        end else if (start) begin
          next_state = ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.redir_valid) begin
          next_pc    = bus.redir_addr;
          next_valid = 1'b0;
          next_state = ST_REQ;
        end else if (bus.imem_ack) begin
          next_instr   = bus.imem_rdata;
          next_held_pc = pc;
          next_pc      = pc_plus;
          next_valid   = 1'b1;
          next_state   = ST_HOLD;
        end else begin
`ifdef PC_SEQ_TIMEOUT_EN
          if (cnt == CNT_LAST) begin
            timeout_hit = 1'b1;
            next_state  = ST_IDLE;
          end else begin
            next_cnt   = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            next_state = ST_REQ;
          end
`else
          next_state = ST_REQ;
`endif
        end
      end
      ST_HOLD: begin
        if (bus.redir_valid) begin
          next_pc    = bus.redir_addr;
          next_valid = 1'b0;
          next_state = ST_REQ;
        end else if (bus.instr_ready) begin
          next_valid = 1'b0;
          next_state = halt ? ST_IDLE : ST_REQ;
        end else begin
          next_state = ST_HOLD;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_valid = 1'b0;
      end
    endcase
  end

  // State, PC, held instruction and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= ADDR_W'(RESET_PC);
      held_instr <= {INSTR_W{1'b0}};
      held_pc    <= {ADDR_W{1'b0}};
      valid      <= 1'b0;
      req        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      pc         <= next_pc;
      held_instr <= next_instr;
      held_pc    <= next_held_pc;
      valid      <= next_valid;
      req        <= (next_state == ST_REQ);
      busy       <= (next_state != ST_IDLE);
    end
  end

`ifdef PC_SEQ_TIMEOUT_EN
  // Fetch-wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
      err <= 1'b0;
    end else begin
      cnt <= next_cnt;
      err <= err | timeout_hit;
    end
  end
  assign fetch_err = err;
`else
  assign fetch_err = 1'b0;
`endif

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_out   = held_instr;
  assign bus.instr_pc    = held_pc;
  assign bus.instr_valid = valid;

endmodule
